mul_seq: RTL and testbench
==========================

MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter PW, default 3, so register address ports are PW+1 bits wide, matching the register file write port.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to multiply; sampled only in IDLE.
REQ-005 SHALL have port opA, input, 8, multiplicand, from register file read port A.
REQ-006 SHALL have port opB, input, 8, multiplier, from register file read port B.
REQ-007 SHALL have port dst_lo, input, PW+1, destination register for the product low byte.
REQ-008 SHALL have port dst_hi, input, PW+1, destination register for the product high byte.
REQ-009 SHALL have port wr_en, output, 1, write strobe to the register file.
REQ-010 SHALL have port wr_addr, output, PW+1, register file write address.
REQ-011 SHALL have port dat_out, output, 8, register file write data.
REQ-012 SHALL have port busy, output, 1, high while an operation is in flight.
REQ-013 SHALL have port done, output, 1, one-cycle pulse on completion.

Function
REQ-014 SHALL implement four states: IDLE, CALC, WB_LO, WB_HI.
REQ-015 IDLE with start=1 at a posedge SHALL latch opA, opB, dst_lo, dst_hi, clear the 16-bit accumulator and 3-bit counter, and enter CALC.
REQ-016 IDLE with start=0 SHALL remain in IDLE with no register changes.
REQ-017 CALC SHALL last exactly 8 cycles: on step i (i=0..7), acc += {8'b0,A} << i if B[i]=1.
REQ-018 Arithmetic SHALL be unsigned 8x8->16; the accumulator SHALL never overflow or wrap (max 0xFE01).
REQ-019 After counter value 7, the FSM SHALL go to WB_LO.
REQ-020 WB_LO SHALL drive wr_en=1, wr_addr=dst_lo and dat_out=acc[7:0] for one cycle, then go to WB_HI.
REQ-021 WB_HI SHALL drive wr_en=1, wr_addr=dst_hi, dat_out=acc[15:8] and done=1 for one cycle, then go to IDLE.
REQ-022 Latency: with start sampled at edge E0, the WB_LO cycle SHALL be cycle 9 after E0 and the WB_HI cycle cycle 10; the next start SHALL be accepted at the edge ending WB_HI+1 (IDLE).
REQ-023 busy SHALL be 1 in CALC, WB_LO and WB_HI, and 0 in IDLE.
REQ-024 start while busy=1 SHALL be ignored; the in-flight operation and its latched operands SHALL be unaffected by input changes.
REQ-025 In all non-write states, wr_en SHALL be 0 and dat_out and wr_addr SHALL be 0.
REQ-026 If dst_lo equals dst_hi, both writes SHALL still occur, so the high byte is the final register content.
REQ-027 Outputs SHALL be decoded from registered state only, with no combinational path from start/opA/opB to any output.

Reset
REQ-028 reset=1 at a posedge SHALL force IDLE and clear the accumulator, counter and latched operands/addresses from any state, including mid-CALC or WB.
REQ-029 During and after reset, wr_en, done and busy SHALL be 0, and wr_addr and dat_out SHALL be 0.
REQ-030 An aborted operation SHALL produce no register write and no done pulse.
REQ-031 reset SHALL take priority over start in the same cycle.

Structure
REQ-032 The state enum and constant MUL_STEPS=8 SHALL reside in the shared processor package.
REQ-033 The block SHALL be a single module with no sub-modules; the accumulator and counter are inline.

Verification
REQ-034 A=13, B=11, dst_lo=2, dst_hi=3 SHALL give writes reg2<=0x8F at cycle 9 and reg3<=0x00 at cycle 10 with done, checked by the paired reg file.
REQ-035 A=0xFF, B=0xFF SHALL give writes 0x01 then 0xFE, with busy high for exactly 10 cycles.
REQ-036 start pulsed at cycle 4 with different operands SHALL leave the result unchanged from the first operation, with only two write strobes in total.
REQ-037 reset asserted at cycle 5 of CALC SHALL return the block to IDLE next cycle with no wr_en or done, and a fresh start SHALL then complete normally.
REQ-038 A=7, B=9, dst_lo=dst_hi=4 SHALL write 0x3F then 0x00, leaving reg4=0x00.
REQ-039 Back-to-back starts (start held high) SHALL produce operations every 11 cycles with correct results.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared state encoding and step count for the sequential multiplier
package mul_seq_pkg;
    typedef enum logic [1:0] {IDLE, CALC, WB_LO, WB_HI} mul_state_t;
    localparam int MUL_STEPS = 8;
endpackage

// File: rtl/mul_seq.sv
// mul_seq: shift-and-add 8x8 unsigned multiplier writing its product back as two register-file bytes
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int PW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    opA,
    input  logic [7:0]    opB,
    input  logic [PW:0]   dst_lo,
    input  logic [PW:0]   dst_hi,
    output logic          wr_en,
    output logic [PW:0]   wr_addr,
    output logic [7:0]    dat_out,
    output logic          busy,
    output logic          done
);
    mul_state_t  r_state;
    logic [7:0]  r_a, r_b;
    logic [PW:0] r_dst_lo, r_dst_hi;
    logic [15:0] r_acc;
    logic [2:0]  r_cnt;
    logic        r_wr_en, r_busy, r_done;
    logic [PW:0] r_wr_addr;
    logic [7:0]  r_dat_out;
    logic [15:0] w_acc_nxt;

    assign w_acc_nxt = r_acc + (r_b[r_cnt] ? ({8'b0, r_a} << r_cnt) : 16'd0);

    // Outputs are registered alongside the state so nothing combinational reaches a port
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_dst_lo  <= '0;
            r_dst_hi  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_dat_out <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_a      <= opA;
                    r_b      <= opB;
                    r_dst_lo <= dst_lo;
                    r_dst_hi <= dst_hi;
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_busy   <= 1'b1;
                    r_state  <= CALC;
                end
                CALC: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'(MUL_STEPS - 1)) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_dst_lo;
                        r_dat_out <= w_acc_nxt[7:0];
                        r_state   <= WB_LO;
                    end
                end
                WB_LO: begin
                    r_wr_addr <= r_dst_hi;
                    r_dat_out <= r_acc[15:8];
                    r_done    <= 1'b1;
                    r_state   <= WB_HI;
                end
                default: begin
                    r_wr_en   <= 1'b0;
                    r_wr_addr <= '0;
                    r_dat_out <= '0;
                    r_done    <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign dat_out = r_dat_out;
    assign busy    = r_busy;
    assign done    = r_done;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed checks of mul_seq timing, results, abort and back-to-back behaviour
module tb_mul_seq;
    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] opA, opB;
    logic [3:0] dst_lo, dst_hi;
    logic       wr_en, busy, done;
    logic [3:0] wr_addr;
    logic [7:0] dat_out;
    logic [7:0] regs [16];
    int         checks = 0, errors = 0, wr_cnt = 0, busy_cnt = 0;

    mul_seq #(.PW(3)) dut (
        .clk(clk), .reset(reset), .start(start), .opA(opA), .opB(opB),
        .dst_lo(dst_lo), .dst_hi(dst_hi), .wr_en(wr_en), .wr_addr(wr_addr),
        .dat_out(dat_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Paired register file plus strobe and busy-cycle counters
    always @(posedge clk) begin
        if (wr_en) begin
            regs[wr_addr] <= dat_out;
            wr_cnt <= wr_cnt + 1;
        end
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, {15'd0, busy}, 16'd0);
        chk({tag, "_wr_en"}, {15'd0, wr_en}, 16'd0);
        chk({tag, "_done"}, {15'd0, done}, 16'd0);
        chk({tag, "_addr"}, {12'd0, wr_addr}, 16'd0);
        chk({tag, "_dat"}, {8'd0, dat_out}, 16'd0);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] lo, input logic [3:0] hi,
                          input logic [7:0] exp_lo, input logic [7:0] exp_hi,
                          input bit poke, input bit hold);
        int w0, b0;
        w0 = wr_cnt;
        b0 = busy_cnt;
        start = 1'b1; opA = a; opB = b; dst_lo = lo; dst_hi = hi;
        tick;
        start = hold;
        opA = 8'($urandom); opB = 8'($urandom);
        dst_lo = 4'($urandom); dst_hi = 4'($urandom);
        chk({tag, "_calc_busy"}, {15'd0, busy}, 16'd1);
        chk({tag, "_calc_wr"}, {15'd0, wr_en}, 16'd0);
        repeat (3) tick;
        if (poke) begin
            start = 1'b1; opA = 8'h5A; opB = 8'hC3; dst_lo = 4'd9; dst_hi = 4'd10;
        end
        tick;
        start = hold;
        repeat (3) tick;
        chk({tag, "_calc_end_wr"}, {15'd0, wr_en}, 16'd0);
        chk({tag, "_calc_end_dat"}, {8'd0, dat_out}, 16'd0);
        tick;
        chk({tag, "_lo_wr"}, {15'd0, wr_en}, 16'd1);
        chk({tag, "_lo_addr"}, {12'd0, wr_addr}, {12'd0, lo});
        chk({tag, "_lo_dat"}, {8'd0, dat_out}, {8'd0, exp_lo});
        chk({tag, "_lo_done"}, {15'd0, done}, 16'd0);
        tick;
        chk({tag, "_hi_wr"}, {15'd0, wr_en}, 16'd1);
        chk({tag, "_hi_addr"}, {12'd0, wr_addr}, {12'd0, hi});
        chk({tag, "_hi_dat"}, {8'd0, dat_out}, {8'd0, exp_hi});
        chk({tag, "_hi_done"}, {15'd0, done}, 16'd1);
        chk({tag, "_reg_lo"}, {8'd0, regs[lo]}, {8'd0, exp_lo});
        tick;
        chk_idle({tag, "_end"});
        chk({tag, "_reg_hi"}, {8'd0, regs[hi]}, {8'd0, exp_hi});
        chk({tag, "_strobes"}, 16'(wr_cnt - w0), 16'd2);
        chk({tag, "_busy_cycles"}, 16'(busy_cnt - b0), 16'd10);
    endtask

    initial begin
        reset = 1'b1; start = 1'b1; opA = 8'h12; opB = 8'h34; dst_lo = 4'd1; dst_hi = 4'd2;
        for (int i = 0; i < 16; i++) regs[i] = 8'hAA;
        tick;
        tick;
        chk_idle("reset");
        reset = 1'b0; start = 1'b0;
        tick;
        chk_idle("idle_nostart");

        run_op("basic", 8'd13, 8'd11, 4'd2, 4'd3, 8'h8F, 8'h00, 1'b0, 1'b0);
        run_op("max", 8'hFF, 8'hFF, 4'd5, 4'd6, 8'h01, 8'hFE, 1'b0, 1'b0);
        run_op("poke", 8'd13, 8'd11, 4'd7, 4'd8, 8'h8F, 8'h00, 1'b1, 1'b0);
        chk("poke_no_extra_reg9", {8'd0, regs[9]}, 16'h00AA);
        run_op("same_dst", 8'd7, 8'd9, 4'd4, 4'd4, 8'h3F, 8'h00, 1'b0, 1'b0);
        chk("same_dst_final", {8'd0, regs[4]}, 16'h0000);

        // Abort mid-CALC: nothing may be written and no done may appear
        begin
            int w0;
            w0 = wr_cnt;
            start = 1'b1; opA = 8'd100; opB = 8'd100; dst_lo = 4'd11; dst_hi = 4'd12;
            tick;
            start = 1'b0;
            repeat (4) tick;
            chk("abort_mid_busy", {15'd0, busy}, 16'd1);
            reset = 1'b1; start = 1'b1;
            tick;
            reset = 1'b0; start = 1'b0;
            chk_idle("abort");
            repeat (12) begin
                tick;
                chk("abort_no_done", {15'd0, done | busy}, 16'd0);
            end
            chk("abort_no_writes", 16'(wr_cnt - w0), 16'd0);
            chk("abort_reg11", {8'd0, regs[11]}, 16'h00AA);
        end
        run_op("after_abort", 8'd200, 8'd3, 4'd11, 4'd12, 8'h58, 8'h02, 1'b0, 1'b0);

        run_op("b2b_0", 8'd17, 8'd19, 4'd13, 4'd14, 8'h43, 8'h01, 1'b0, 1'b1);
        run_op("b2b_1", 8'hF0, 8'h0F, 4'd15, 4'd0, 8'h10, 8'h0E, 1'b0, 1'b1);
        run_op("b2b_2", 8'd1, 8'd128, 4'd1, 4'd2, 8'h80, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
